// File: rtl/instr_fetch_responder.sv
// Single-line instruction fetch buffer: answers instruction-register fetches from a
// 32-byte line and refills that line from backing memory on a miss.
module instr_fetch_responder (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         instr_read,
    input  logic [31:0]  instr_mem_address,
    output logic         instr_mem_resp,
    output logic [31:0]  instr_mem_rdata,
    input  logic         flush,
    output logic         pmem_read,
    output logic [31:0]  pmem_address,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FILL_DISCARD,
        RESPOND
    } state_t;

    state_t        state;
    logic          valid;
    logic [26:0]   tag;
    logic [255:0]  data;
    logic [31:0]   req_addr;
    logic          resp_q;
    logic [31:0]   rdata_q;
    logic          hit;
    logic          line_we;
    logic          unused_addr_bits;

    function automatic logic [31:0] word_sel(input logic [255:0] line, input logic [2:0] idx);
        return line[{idx, 5'b0} +: 32];
    endfunction

    assign hit     = valid && (tag == instr_mem_address[31:5]);
    assign line_we = pmem_resp && ((state == FILL) || (state == FILL_DISCARD));

    // Byte offset within a word never selects anything; fetches are word-granular.
    assign unused_addr_bits = ^{instr_mem_address[1:0], req_addr[1:0]};

    // NOTE: the line storage has no reset; valid=0 guards it, so clearing 283 flops buys nothing.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data <= pmem_rdata;
            tag  <= req_addr[31:5];
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            valid        <= 1'b0;
            req_addr     <= '0;
            resp_q       <= 1'b0;
            rdata_q      <= '0;
            pmem_read    <= 1'b0;
            pmem_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_q  <= 1'b0;
                    rdata_q <= '0;
                    if (instr_read) begin
                        req_addr <= instr_mem_address;
                        if (hit) begin
                            state   <= RESPOND;
                            resp_q  <= 1'b1;
                            rdata_q <= word_sel(data, instr_mem_address[4:2]);
                        end else begin
                            state        <= FILL;
                            pmem_read    <= 1'b1;
                            pmem_address <= {instr_mem_address[31:5], 5'b0};
                        end
                    end
                end

                FILL: begin
                    if (pmem_resp) begin
                        valid     <= 1'b1;
                        pmem_read <= 1'b0;
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            state   <= RESPOND;
                            resp_q  <= 1'b1;
                            rdata_q <= word_sel(pmem_rdata, req_addr[4:2]);
                        end
                    end else if (flush) begin
                        // The memory transfer cannot be aborted; finish it but drop the answer.
                        state <= FILL_DISCARD;
                    end
                end

                FILL_DISCARD: begin
                    if (pmem_resp) begin
                        valid     <= 1'b1;
                        pmem_read <= 1'b0;
                        state     <= IDLE;
                    end
                end

                RESPOND: begin
                    resp_q  <= 1'b0;
                    rdata_q <= '0;
                    state   <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    resp_q    <= 1'b0;
                    rdata_q   <= '0;
                    pmem_read <= 1'b0;
                end
            endcase
        end
    end

    // A redirect arriving in the response cycle must suppress the strobe that same cycle.
    assign instr_mem_resp  = resp_q & ~flush;
    assign instr_mem_rdata = instr_mem_resp ? rdata_q : 32'h0;

    resp_fill_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(pmem_read && instr_mem_resp));

endmodule

// File: doc/instr_fetch_responder.md
INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 SHALL have no parameters; line size is fixed at 32 bytes (8 x 32-bit words).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: instr_read  input  1  fetch request from the instruction register.
REQ-005 SHALL have port: instr_mem_address  input  32  fetch byte address.
REQ-006 SHALL have port: instr_mem_resp  output  1  one-cycle response strobe.
REQ-007 SHALL have port: instr_mem_rdata  output  32  fetched instruction; drives the instruction register `in` port.
REQ-008 SHALL have port: flush  input  1  pipeline redirect (branch mispredict / load_pc); cancels the pending response.
REQ-009 SHALL have port: pmem_read  output  1  line-fill request to backing memory.
REQ-010 SHALL have port: pmem_address  output  32  line-aligned fill address.
REQ-011 SHALL have port: pmem_rdata  input  256  fill line; word k at bits [32k+31:32k].
REQ-012 SHALL have port: pmem_resp  input  1  fill-complete strobe; pmem_rdata is valid in the same cycle.

Function
REQ-013 SHALL hold a single-line buffer with these fields: valid (1 bit), tag = address[31:5], data (256 bits).
REQ-014 SHALL implement an FSM with states IDLE, FILL, FILL_DISCARD and RESPOND, all registered.
REQ-015 In IDLE with instr_read=1, SHALL latch instr_mem_address into req_addr.
REQ-016 In IDLE with instr_read=1 and a hit (valid and tag == address[31:5]), SHALL go to RESPOND.
REQ-017 In IDLE with instr_read=1 and a miss, SHALL go to FILL.
REQ-018 In IDLE with instr_read=0, SHALL stay in IDLE.
REQ-019 In FILL, SHALL assert pmem_read=1 with pmem_address = {req_addr[31:5], 5'b0}, held stable until pmem_resp.
REQ-020 In FILL on pmem_resp, SHALL write data and tag, set valid=1, drop pmem_read the next cycle, and go to RESPOND.
REQ-021 In RESPOND, SHALL assert instr_mem_resp=1 for exactly one cycle with instr_mem_rdata = data word req_addr[4:2], then return to IDLE.
REQ-022 Hit latency SHALL be 1 cycle: request sampled at edge N, response high in cycle N+1.
REQ-023 Miss latency SHALL be 1 cycle after the pmem_resp edge.
REQ-024 SHALL ignore address bits [1:0].
REQ-025 Requester SHALL hold instr_read and instr_mem_address stable until instr_mem_resp; the responder SHALL NOT re-sample them outside IDLE.
REQ-026 instr_read still high in the first IDLE cycle after a response SHALL be treated as a new request.
REQ-027 flush in IDLE SHALL have no effect; the line is not invalidated.
REQ-028 flush in FILL SHALL go to FILL_DISCARD, keeping pmem_read asserted, since a backing-memory transfer cannot be aborted.
REQ-029 FILL_DISCARD on pmem_resp SHALL write the line, set valid=1, return to IDLE, and produce no instr_mem_resp.
REQ-030 flush in the RESPOND cycle SHALL force instr_mem_resp=0 and return to IDLE.
REQ-031 If flush and pmem_resp occur in the same FILL cycle, SHALL write the line and go to IDLE with no response.
REQ-032 instr_mem_rdata SHALL be 0 whenever instr_mem_resp=0.
REQ-033 pmem_read and instr_mem_resp SHALL never be high in the same cycle.

Reset
REQ-034 reset_n=0 SHALL asynchronously force state=IDLE, valid=0, req_addr=0, instr_mem_resp=0, instr_mem_rdata=0, pmem_read=0 and pmem_address=0.
REQ-035 Reset mid-FILL SHALL drop pmem_read immediately.
REQ-036 A pmem_resp arriving during or after reset without a pending FILL SHALL be ignored.
REQ-037 Data and tag contents need not be cleared on reset; valid=0 makes them unused.

Verification
REQ-038 Cold miss: reset, then instr_read=1 at address 0x60 -> pmem_read=1 with pmem_address=0x60; pmem_resp with words {000170b3, 0001f133, 000271b3, 00b08093, 00c10113, 00d18193, 0, 0} -> next cycle instr_mem_resp=1 and rdata=000170b3 for one cycle.
REQ-039 Hit: then read 0x6C -> instr_mem_resp=1 one cycle after the request with rdata=00b08093 and pmem_read remaining 0 throughout.
REQ-040 Replace: read 0x80 -> fill of 0x80; then read 0x64 -> miss, pmem_address=0x60, rdata=0001f133.
REQ-041 Flush during fill: read 0xA0, pulse flush before pmem_resp -> pmem_read held until pmem_resp and no instr_mem_resp; then read 0xA4 -> 1-cycle hit.
REQ-042 Unaligned and reset-abort: read 0x67 -> rdata = word 1; assert reset_n=0 mid-FILL -> pmem_read=0 immediately, and after reset read 0x60 misses.
